// File: rtl/fft8_pkg.sv
// fft8_pkg: shared definitions for the 8-point FFT sequencer.
//   - fft_state_t : controller phases (LOAD, COMPUTE, UNLOAD)
//   - NPOINT, STAGES : transform size and number of radix-2 stages
//   - W8_1_*, W8_3_* : Q1.15 twiddles W8^1 = (c,-c), W8^3 = (-c,-c), c = cos(pi/4)
//   - bitrev3() : 3-bit bit reversal used for the load address
package fft8_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      UNLOAD  = 2'd2
   } fft_state_t;

   localparam int NPOINT = 8;
   localparam int STAGES = 3;

   localparam int W8_1_RE =  23170;
   localparam int W8_1_IM = -23170;
   localparam int W8_3_RE = -23170;
   localparam int W8_3_IM = -23170;

   function automatic logic [2:0] bitrev3(input logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

endpackage

// File: rtl/fft8_bfly.sv
// fft8_bfly: combinational radix-2 DIT butterfly.
//   top_real/top_imag : upper operand A
//   bot_real/bot_imag : lower operand B
//   k                 : twiddle index into W8^k (k = 0..3)
//   sum_real/sum_imag : A + W8^k * B   (wraps at DATA_WIDTH)
//   dif_real/dif_imag : A - W8^k * B   (wraps at DATA_WIDTH)
// k=0 and k=2 are exact (pass-through / multiply by -j); k=1 and k=3 use a
// full-precision multiply followed by a floor shift and truncation.
module fft8_bfly
   import fft8_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int TW_WIDTH   = 16
) (
   input  logic signed [DATA_WIDTH-1:0] top_real,
   input  logic signed [DATA_WIDTH-1:0] top_imag,
   input  logic signed [DATA_WIDTH-1:0] bot_real,
   input  logic signed [DATA_WIDTH-1:0] bot_imag,
   input  logic        [1:0]            k,
   output logic signed [DATA_WIDTH-1:0] sum_real,
   output logic signed [DATA_WIDTH-1:0] sum_imag,
   output logic signed [DATA_WIDTH-1:0] dif_real,
   output logic signed [DATA_WIDTH-1:0] dif_imag
);

   localparam int PW = DATA_WIDTH + TW_WIDTH + 1;
   localparam int SH = TW_WIDTH - 1;

   logic signed [TW_WIDTH-1:0]   w_re_s;
   logic signed [TW_WIDTH-1:0]   w_im_s;
   logic signed [PW-1:0]         prod_re_s;
   logic signed [PW-1:0]         prod_im_s;
   logic signed [DATA_WIDTH-1:0] t_re_s;
   logic signed [DATA_WIDTH-1:0] t_im_s;

   // Odd-index twiddle select; both odd twiddles share the same imaginary part.
   always_comb begin
      w_im_s = TW_WIDTH'(W8_1_IM);
      if (k[1]) begin
         w_re_s = TW_WIDTH'(W8_3_RE);
      end else begin
         w_re_s = TW_WIDTH'(W8_1_RE);
      end
   end

   // Full-precision complex product B*W; operands sign-extended before multiplying.
   always_comb begin
      prod_re_s = PW'(bot_real) * PW'(w_re_s) - PW'(bot_imag) * PW'(w_im_s);
      prod_im_s = PW'(bot_real) * PW'(w_im_s) + PW'(bot_imag) * PW'(w_re_s);
   end

   // Twiddled operand t: exact bypass for k=0 and k=2, floor-scaled product otherwise.
   always_comb begin
      case (k)
         2'd0: begin
            t_re_s = bot_real;
            t_im_s = bot_imag;
         end
         2'd2: begin
            // (Br + jBi) * (-j) = Bi - jBr
            t_re_s = bot_imag;
            t_im_s = -bot_real;
         end
         2'd1, 2'd3: begin
            t_re_s = DATA_WIDTH'(prod_re_s >>> SH);
            t_im_s = DATA_WIDTH'(prod_im_s >>> SH);
         end
         default: begin
            t_re_s = bot_real;
            t_im_s = bot_imag;
         end
      endcase
   end

   assign sum_real = top_real + t_re_s;
   assign sum_imag = top_imag + t_im_s;
   assign dif_real = top_real - t_re_s;
   assign dif_imag = top_imag - t_im_s;

endmodule

// File: rtl/fft8_seq_ctrl.sv
// fft8_seq_ctrl: sequencer for an in-place 8-point radix-2 DIT FFT.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input stream handshake, in_real/in_imag x[0] first
//   out_valid/out_ready   : output stream handshake, out_real/out_imag X[0] first
//   busy                  : high while computing or unloading
// Samples are written in bit-reversed order, 12 butterflies run one per cycle
// (3 stages x 4), then the register file is read out in natural order.
module fft8_seq_ctrl
   import fft8_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int TW_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_real,
   input  logic signed [DATA_WIDTH-1:0] in_imag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_real,
   output logic signed [DATA_WIDTH-1:0] out_imag,
   output logic                         busy
);

   localparam logic [3:0] LOAD_LAST = 4'(NPOINT - 1);
   localparam logic [3:0] BFLY_LAST = 4'(STAGES * (NPOINT / 2) - 1);

   fft_state_t state_r, state_nxt;
   logic [3:0] cnt_r, cnt_nxt;

   logic signed [DATA_WIDTH-1:0] mem_re_r [NPOINT];
   logic signed [DATA_WIDTH-1:0] mem_im_r [NPOINT];

   logic [1:0] stage_s;
   logic [1:0] bidx_s;
   logic [2:0] top_s;
   logic [2:0] bot_s;
   logic [1:0] k_s;

   logic signed [DATA_WIDTH-1:0] sum_re_s, sum_im_s, dif_re_s, dif_im_s;

   logic in_ready_r;
   logic out_valid_r;
   logic busy_r;

   // The shared counter is the load index, the butterfly number or the unload index.
   assign stage_s = cnt_r[3:2];
   assign bidx_s  = cnt_r[1:0];

   // Butterfly address/twiddle generation; the bit patterns are the
   // top=((b>>s)<<(s+1))+pos, bot=top+h, k=pos<<(2-s) rules unrolled per stage.
   always_comb begin
      case (stage_s)
         2'd0: begin
            top_s = {bidx_s, 1'b0};
            bot_s = {bidx_s, 1'b1};
            k_s   = 2'd0;
         end
         2'd1: begin
            top_s = {bidx_s[1], 1'b0, bidx_s[0]};
            bot_s = {bidx_s[1], 1'b1, bidx_s[0]};
            k_s   = {bidx_s[0], 1'b0};
         end
         2'd2: begin
            top_s = {1'b0, bidx_s};
            bot_s = {1'b1, bidx_s};
            k_s   = bidx_s;
         end
         default: begin
            top_s = 3'd0;
            bot_s = 3'd1;
            k_s   = 2'd0;
         end
      endcase
   end

   fft8_bfly #(
      .DATA_WIDTH (DATA_WIDTH),
      .TW_WIDTH   (TW_WIDTH)
   ) u_bfly (
      .top_real (mem_re_r[top_s]),
      .top_imag (mem_im_r[top_s]),
      .bot_real (mem_re_r[bot_s]),
      .bot_imag (mem_im_r[bot_s]),
      .k        (k_s),
      .sum_real (sum_re_s),
      .sum_imag (sum_im_s),
      .dif_real (dif_re_s),
      .dif_imag (dif_im_s)
   );

   // Next-state and counter logic for the LOAD -> COMPUTE -> UNLOAD cycle.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      case (state_r)
         LOAD: begin
            if (in_valid) begin
               if (cnt_r == LOAD_LAST) begin
                  state_nxt = COMPUTE;
                  cnt_nxt   = 4'd0;
               end else begin
                  cnt_nxt = cnt_r + 4'd1;
               end
            end else begin
               cnt_nxt = cnt_r;
            end
         end
         COMPUTE: begin
            if (cnt_r == BFLY_LAST) begin
               state_nxt = UNLOAD;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt_r + 4'd1;
            end
         end
         UNLOAD: begin
            if (out_ready) begin
               if (cnt_r == LOAD_LAST) begin
                  state_nxt = LOAD;
                  cnt_nxt   = 4'd0;
               end else begin
                  cnt_nxt = cnt_r + 4'd1;
               end
            end else begin
               cnt_nxt = cnt_r;
            end
         end
         default: begin
            state_nxt = LOAD;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State, counter, handshake flags and in-place register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= LOAD;
         cnt_r       <= 4'd0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         for (int i = 0; i < NPOINT; i++) begin
            mem_re_r[i] <= '0;
            mem_im_r[i] <= '0;
         end
      end else begin
         state_r     <= state_nxt;
         cnt_r       <= cnt_nxt;
         // Flags follow the next state so they line up with the state register.
         in_ready_r  <= (state_nxt == LOAD);
         out_valid_r <= (state_nxt == UNLOAD);
         busy_r      <= (state_nxt != LOAD);
         if ((state_r == LOAD) && in_valid) begin
            mem_re_r[bitrev3(cnt_r[2:0])] <= in_real;
            mem_im_r[bitrev3(cnt_r[2:0])] <= in_imag;
         end else if (state_r == COMPUTE) begin
            mem_re_r[top_s] <= sum_re_s;
            mem_im_r[top_s] <= sum_im_s;
            mem_re_r[bot_s] <= dif_re_s;
            mem_im_r[bot_s] <= dif_im_s;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_real  = out_valid_r ? mem_re_r[cnt_r[2:0]] : '0;
   assign out_imag  = out_valid_r ? mem_im_r[cnt_r[2:0]] : '0;

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// tb_fft8_seq_ctrl: self-checking bench for fft8_seq_ctrl.
// Table of known transforms, backpressure and mid-frame reset sequences, and
// random frames compared against a behavioural FFT model.
module tb_fft8_seq_ctrl;

   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, out_valid, out_ready, busy;
   logic signed [DW-1:0] in_real, in_imag, out_real, out_imag;

   int cyc    = 0;
   int total  = 0;
   int passed = 0;

   typedef struct packed {
      logic [7:0][15:0] xr;
      logic [7:0][15:0] xi;
      logic [7:0][15:0] er;
      logic [7:0][15:0] ei;
   } vec_t;

   vec_t  vecs [4];
   string vnames [4] = '{"impulse", "dc", "shift", "wrap"};
   int    sh_er [8]  = '{1000, 707, 0, -708, -1000, -707, 0, 708};
   int    sh_ei [8]  = '{0, -708, -1000, -708, 0, 708, 1000, 708};

   int xr_a [8], xi_a [8], yr_a [8], yi_a [8], ref_r [8], ref_i [8];
   int lat, acc;

   fft8_seq_ctrl #(.DATA_WIDTH(DW), .TW_WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_real  (out_real),
      .out_imag  (out_imag),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int s16(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic int wrap16(input longint v);
      logic [15:0] t;
      t = v[15:0];
      return s16(t);
   endfunction

   // Behavioural 8-point DIT FFT following the documented arithmetic rules.
   function automatic void ref_fft(input int xr[8], input int xi[8],
                                   output int yr[8], output int yi[8]);
      int ar[8], ai[8];
      int h, pos, top, bot, k, br, bi, tr, ti, wr, wi, a_r, a_i;
      for (int n = 0; n < 8; n++) begin
         int r;
         r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
         ar[r] = xr[n];
         ai[r] = xi[n];
      end
      for (int s = 0; s < 3; s++) begin
         h = 1 << s;
         for (int b = 0; b < 4; b++) begin
            pos = b % h;
            top = (b / h) * 2 * h + pos;
            bot = top + h;
            k   = pos * (4 >> s);
            br  = ar[bot];
            bi  = ai[bot];
            case (k)
               0: begin tr = br; ti = bi; end
               2: begin tr = bi; ti = wrap16(-br); end
               default: begin
                  wr = (k == 1) ? 23170 : -23170;
                  wi = -23170;
                  tr = wrap16((longint'(br) * wr - longint'(bi) * wi) >>> 15);
                  ti = wrap16((longint'(br) * wi + longint'(bi) * wr) >>> 15);
               end
            endcase
            a_r = ar[top];
            a_i = ai[top];
            ar[top] = wrap16(a_r + tr);
            ai[top] = wrap16(a_i + ti);
            ar[bot] = wrap16(a_r - tr);
            ai[bot] = wrap16(a_i - ti);
         end
      end
      yr = ar;
      yi = ai;
   endfunction

   // Feed 8 samples; returns the cycle number of the 8th accept.
   task automatic load_frame(input int xr[8], input int xi[8], input bit gaps,
                             output int acc_cyc);
      int n = 0;
      int guard = 0;
      acc_cyc = -1;
      while (n < 8 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_real  = 16'($urandom);
            in_imag  = 16'($urandom);
         end else begin
            in_valid = 1'b1;
            in_real  = 16'(xr[n]);
            in_imag  = 16'(xi[n]);
         end
         if (in_valid && in_ready) begin
            if (n == 7) acc_cyc = cyc;
            n++;
         end
      end
      check("load_accepts", n, 8);
   endtask

   // Collect 8 outputs; mode 0 ready high, 1 stall-then-toggle, 2 random ready.
   task automatic unload_frame(input int mode, output int yr[8], output int yi[8],
                               output int first_cyc);
      int m = 0, guard = 0, stall = 0, hr = 0, hi = 0;
      bit held = 1'b0;
      bit bad = 1'b0;
      first_cyc = -1;
      for (int i = 0; i < 8; i++) begin yr[i] = 0; yi[i] = 0; end
      while (m < 8 && guard < 400) begin
         @(negedge clk);
         guard++;
         // Junk on the input side must be ignored outside LOAD.
         in_valid = 1'($urandom_range(0, 1));
         in_real  = 16'($urandom);
         in_imag  = 16'($urandom);
         case (mode)
            0: out_ready = 1'b1;
            1: begin
               if (m < 3) out_ready = 1'b1;
               else if (stall < 5) begin out_ready = 1'b0; stall++; end
               else out_ready = ~out_ready;
            end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (in_ready || !busy) bad = 1'b1;
            if (!out_ready) begin
               if (held) begin
                  check("stall_stable_re", int'(out_real), hr);
                  check("stall_stable_im", int'(out_imag), hi);
               end else begin
                  held = 1'b1;
                  hr = int'(out_real);
                  hi = int'(out_imag);
               end
            end else begin
               yr[m] = int'(out_real);
               yi[m] = int'(out_imag);
               m++;
               held = 1'b0;
            end
         end
      end
      check("unload_accepts", m, 8);
      check("unload_flags", int'(bad), 0);
   endtask

   task automatic run_frame(input int xr[8], input int xi[8], input bit gaps,
                            input int mode, output int yr[8], output int yi[8],
                            output int latency);
      int a, f;
      load_frame(xr, xi, gaps, a);
      unload_frame(mode, yr, yi, f);
      latency = f - a;
      // Cycle after the 8th output accept: back in LOAD.
      @(negedge clk);
      in_valid = 1'b0;
      check("boundary_in_ready", int'(in_ready), 1);
      check("boundary_out_valid", int'(out_valid), 0);
      check("boundary_busy", int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_imag = '0;

      for (int v = 0; v < 4; v++) vecs[v] = '0;
      for (int i = 0; i < 8; i++) begin
         vecs[0].er[i] = 16'd1000;
         vecs[1].xr[i] = 16'd1000;
         vecs[2].er[i] = 16'(sh_er[i]);
         vecs[2].ei[i] = 16'(sh_ei[i]);
         if (i % 2 == 0) vecs[3].er[i] = 16'(-25536);
      end
      vecs[0].xr[0] = 16'd1000;
      vecs[1].er[0] = 16'd8000;
      vecs[2].xr[1] = 16'd1000;
      vecs[3].xr[0] = 16'd20000;
      vecs[3].xr[4] = 16'd20000;

      repeat (3) @(negedge clk);
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_out_real", int'(out_real), 0);
      check("reset_out_imag", int'(out_imag), 0);
      rst = 1'b0;

      // Table-driven known transforms.
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 8; i++) begin
            xr_a[i] = s16(vecs[v].xr[i]);
            xi_a[i] = s16(vecs[v].xi[i]);
         end
         run_frame(xr_a, xi_a, 1'b0, 0, yr_a, yi_a, lat);
         check($sformatf("%s_latency", vnames[v]), lat, 13);
         for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_X%0d_re", vnames[v], i), yr_a[i], s16(vecs[v].er[i]));
            check($sformatf("%s_X%0d_im", vnames[v], i), yi_a[i], s16(vecs[v].ei[i]));
         end
      end

      // Backpressure on the shifted impulse.
      for (int i = 0; i < 8; i++) begin
         xr_a[i] = s16(vecs[2].xr[i]);
         xi_a[i] = s16(vecs[2].xi[i]);
      end
      run_frame(xr_a, xi_a, 1'b0, 1, yr_a, yi_a, lat);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bp_X%0d_re", i), yr_a[i], sh_er[i]);
         check($sformatf("bp_X%0d_im", i), yi_a[i], sh_ei[i]);
      end

      // Reset during COMPUTE cycle 6 aborts the frame.
      for (int i = 0; i < 8; i++) begin xr_a[i] = 1000; xi_a[i] = 0; end
      load_frame(xr_a, xi_a, 1'b0, acc);
      @(negedge clk);
      in_valid = 1'b0;
      check("compute_busy", int'(busy), 1);
      check("compute_in_ready", int'(in_ready), 0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_busy", int'(busy), 0);
      rst = 1'b0;
      run_frame(xr_a, xi_a, 1'b0, 0, yr_a, yi_a, lat);
      check("abort_dc_latency", lat, 13);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("abort_dc_X%0d_re", i), yr_a[i], (i == 0) ? 8000 : 0);
         check($sformatf("abort_dc_X%0d_im", i), yi_a[i], 0);
      end

      // Random frames against the behavioural model.
      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < 8; i++) begin
            xr_a[i] = s16(16'($urandom));
            xi_a[i] = s16(16'($urandom));
         end
         ref_fft(xr_a, xi_a, ref_r, ref_i);
         run_frame(xr_a, xi_a, 1'b1, 2, yr_a, yi_a, lat);
         check($sformatf("rand%0d_latency", f), lat, 13);
         for (int i = 0; i < 8; i++) begin
            check($sformatf("rand%0d_X%0d_re", f, i), yr_a[i], ref_r[i]);
            check($sformatf("rand%0d_X%0d_im", f, i), yi_a[i], ref_i[i]);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
